// File: rtl/riscv_ex_wb_buffer.sv
// Two-entry elastic result buffer between the EX-stage ALU and the writeback port.
// Optional stall counter enabled by defining RISCV_EXWB_PERF_EN.
module riscv_ex_wb_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 6,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_result_i,
    input  logic                  in_cmp_i,
    input  logic [ADDR_WIDTH-1:0] in_waddr_i,
    input  logic                  in_we_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_result_o,
    output logic                  out_cmp_o,
    output logic [ADDR_WIDTH-1:0] out_waddr_o,
    output logic                  out_we_o,
    output logic                  fwd_valid_o,
    output logic [ADDR_WIDTH-1:0] fwd_waddr_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    input  logic                  flush_i
`ifdef RISCV_EXWB_PERF_EN
    ,
    input  logic                  perf_clr_i,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // ready never looks at the partner's valid, and valid never looks at ready.

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] h_result, t_result;
    logic                  h_cmp, t_cmp;
    logic [ADDR_WIDTH-1:0] h_waddr, t_waddr;
    logic                  h_we, t_we;
    logic                  push, pop;

    function automatic logic eff_we(input logic we, input logic [ADDR_WIDTH-1:0] waddr);
        return we && !((ZERO_SUPPRESS != 0) && (waddr == '0));
    endfunction

    assign in_ready_o  = !rst && (count != FULL);
    assign out_valid_o = (count != EMPTY);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= EMPTY;
            h_result <= '0;
            h_cmp    <= 1'b0;
            h_waddr  <= '0;
            h_we     <= 1'b0;
            t_result <= '0;
            t_cmp    <= 1'b0;
            t_waddr  <= '0;
            t_we     <= 1'b0;
        end else if (flush_i) begin
            // Flush drops any concurrent push; stored fields simply go stale.
            count <= EMPTY;
        end else begin
            case (count)
                EMPTY: begin
                    if (push) begin
                        h_result <= in_result_i;
                        h_cmp    <= in_cmp_i;
                        h_waddr  <= in_waddr_i;
                        h_we     <= in_we_i;
                        count    <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        h_result <= in_result_i;
                        h_cmp    <= in_cmp_i;
                        h_waddr  <= in_waddr_i;
                        h_we     <= in_we_i;
                    end else if (push) begin
                        t_result <= in_result_i;
                        t_cmp    <= in_cmp_i;
                        t_waddr  <= in_waddr_i;
                        t_we     <= in_we_i;
                        count    <= FULL;
                    end else if (pop) begin
                        count <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        h_result <= t_result;
                        h_cmp    <= t_cmp;
                        h_waddr  <= t_waddr;
                        h_we     <= t_we;
                        count    <= ONE;
                    end
                end
                default: count <= EMPTY;
            endcase
        end
    end

    assign out_result_o = h_result;
    assign out_cmp_o    = h_cmp;
    assign out_waddr_o  = h_waddr;
    assign out_we_o     = eff_we(h_we, h_waddr);

    // Youngest registered entry: tail when full, otherwise head.
    always_comb begin
        fwd_waddr_o = h_waddr;
        fwd_data_o  = h_result;
        fwd_valid_o = 1'b0;
        if (count == FULL) begin
            fwd_waddr_o = t_waddr;
            fwd_data_o  = t_result;
            fwd_valid_o = eff_we(t_we, t_waddr);
        end else if (count == ONE) begin
            fwd_valid_o = eff_we(h_we, h_waddr);
        end
    end

`ifdef RISCV_EXWB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || perf_clr_i) begin
            perf_stall_cnt_o <= '0;
        end else if (in_valid_i && !in_ready_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == FULL)));
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_o && !out_ready_i && !flush_i) |=>
        ($stable(out_result_o) && $stable(out_cmp_o) && $stable(out_waddr_o) && $stable(out_we_o)));
`endif

endmodule

// File: tb/tb_riscv_ex_wb_buffer.sv
// Self-checking bench for riscv_ex_wb_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based reference of the buffer contents.
module tb_riscv_ex_wb_buffer;

    typedef struct packed {
        logic [31:0] result;
        logic        cmp;
        logic [5:0]  waddr;
        logic        we;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_result_i;
    logic        in_cmp_i;
    logic [5:0]  in_waddr_i;
    logic        in_we_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_result_o;
    logic        out_cmp_o;
    logic [5:0]  out_waddr_o;
    logic        out_we_o;
    logic        fwd_valid_o;
    logic [5:0]  fwd_waddr_o;
    logic [31:0] fwd_data_o;
    logic        flush_i;
`ifdef RISCV_EXWB_PERF_EN
    logic        perf_clr_i;
    logic [31:0] perf_stall_cnt_o;
`endif

    int     checks = 0;
    int     errors = 0;
    entry_t model_q[$];

    riscv_ex_wb_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_result_i  (in_result_i),
        .in_cmp_i     (in_cmp_i),
        .in_waddr_i   (in_waddr_i),
        .in_we_i      (in_we_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_result_o (out_result_o),
        .out_cmp_o    (out_cmp_o),
        .out_waddr_o  (out_waddr_o),
        .out_we_o     (out_we_o),
        .fwd_valid_o  (fwd_valid_o),
        .fwd_waddr_o  (fwd_waddr_o),
        .fwd_data_o   (fwd_data_o),
        .flush_i      (flush_i)
`ifdef RISCV_EXWB_PERF_EN
        ,
        .perf_clr_i       (perf_clr_i),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic writes(input entry_t e);
        return e.we && (e.waddr != 6'd0);
    endfunction

    // Compare every visible output against the reference contents.
    task automatic check_model();
        entry_t h, y;
        chk("out_valid", {31'd0, out_valid_o}, {31'd0, model_q.size() != 0});
        if (model_q.size() == 0) begin
            chk("fwd_valid_empty", {31'd0, fwd_valid_o}, 32'd0);
        end else begin
            h = model_q[0];
            y = model_q[model_q.size()-1];
            chk("out_result", out_result_o, h.result);
            chk("out_cmp", {31'd0, out_cmp_o}, {31'd0, h.cmp});
            chk("out_waddr", {26'd0, out_waddr_o}, {26'd0, h.waddr});
            chk("out_we", {31'd0, out_we_o}, {31'd0, writes(h)});
            chk("fwd_valid", {31'd0, fwd_valid_o}, {31'd0, writes(y)});
            chk("fwd_waddr", {26'd0, fwd_waddr_o}, {26'd0, y.waddr});
            chk("fwd_data", fwd_data_o, y.result);
        end
    endtask

    // One clock: drive inputs, check ready, clock, advance the reference, check outputs.
    task automatic step(input bit v, input logic [31:0] r, input bit c, input logic [5:0] a,
                        input bit we, input bit rdy, input bit fl, input bit rs);
        bit     exp_ready, do_push, do_pop;
        entry_t e;
        in_valid_i  = v;
        in_result_i = r;
        in_cmp_i    = c;
        in_waddr_i  = a;
        in_we_i     = we;
        out_ready_i = rdy;
        flush_i     = fl;
        rst         = rs;
        #1;
        exp_ready = !rs && (model_q.size() < 2);
        chk("in_ready", {31'd0, in_ready_o}, {31'd0, exp_ready});
        do_push = v && exp_ready;
        do_pop  = rdy && (model_q.size() != 0);
        e = '{result: r, cmp: c, waddr: a, we: we};
        @(posedge clk);
        #1;
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        check_model();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] r, input logic [5:0] a, input bit rdy);
        step(1'b1, r, 1'b0, a, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid_i = 0; in_result_i = 0; in_cmp_i = 0; in_waddr_i = 0; in_we_i = 0;
        out_ready_i = 0; flush_i = 0; rst = 1;
`ifdef RISCV_EXWB_PERF_EN
        perf_clr_i = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_result", out_result_o, 32'd0);
        chk("rst_out_we", {31'd0, out_we_o}, 32'd0);
        chk("rst_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
        chk("rst_fwd_data", fwd_data_o, 32'd0);
        chk("rst_fwd_waddr", {26'd0, fwd_waddr_o}, 32'd0);
        idle(1'b0);

        // Single pass
        push(32'h0000_00A5, 6'd3, 1'b1);
        chk("sp_valid", {31'd0, out_valid_o}, 32'd1);
        chk("sp_result", out_result_o, 32'h0000_00A5);
        chk("sp_we", {31'd0, out_we_o}, 32'd1);
        idle(1'b1);
        chk("sp_drained", {31'd0, out_valid_o}, 32'd0);

        // Backpressure fill and ordered drain
        push(32'h11, 6'd1, 1'b0);
        push(32'h22, 6'd2, 1'b0);
        chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("bp_fwd_waddr", {26'd0, fwd_waddr_o}, 32'd2);
        chk("bp_fwd_data", fwd_data_o, 32'h22);
        chk("bp_head", out_result_o, 32'h11);
        idle(1'b1);
        chk("bp_second", out_result_o, 32'h22);
        chk("bp_ready_back", {31'd0, in_ready_o}, 32'd1);
        idle(1'b1);
        chk("bp_empty", {31'd0, out_valid_o}, 32'd0);

        // Simultaneous push and pop while holding one entry
        push(32'h33, 6'd4, 1'b0);
        push(32'h44, 6'd5, 1'b1);
        chk("pp_result", out_result_o, 32'h44);
        chk("pp_one_ready", {31'd0, in_ready_o}, 32'd1);
        idle(1'b1);
        chk("pp_empty", {31'd0, out_valid_o}, 32'd0);

        // Zero suppression, integer x0 versus FP f0
        push(32'hDEAD_BEEF, 6'd0, 1'b0);
        chk("zs_valid", {31'd0, out_valid_o}, 32'd1);
        chk("zs_we", {31'd0, out_we_o}, 32'd0);
        chk("zs_fwd", {31'd0, fwd_valid_o}, 32'd0);
        idle(1'b1);
        push(32'hDEAD_BEEF, 6'h20, 1'b0);
        chk("zs_fp_we", {31'd0, out_we_o}, 32'd1);
        chk("zs_fp_fwd", {31'd0, fwd_valid_o}, 32'd1);
        idle(1'b1);

        // Flush while full with a concurrent push
        push(32'h55, 6'd6, 1'b0);
        push(32'h66, 6'd7, 1'b0);
        step(1'b1, 32'h77, 1'b1, 6'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
        chk("fl_fwd", {31'd0, fwd_valid_o}, 32'd0);

        // Reset mid-operation
        push(32'h88, 6'd9, 1'b0);
        step(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mr_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready_o}, 32'd0);
        idle(1'b0);
        chk("mr_ready_after", {31'd0, in_ready_o}, 32'd1);

`ifdef RISCV_EXWB_PERF_EN
        push(32'h1, 6'd1, 1'b0);
        push(32'h2, 6'd2, 1'b0);
        perf_clr_i = 1;
        step(1'b1, 32'h3, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("perf_clr_prio", perf_stall_cnt_o, 32'd0);
        perf_clr_i = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("perf_cnt5", perf_stall_cnt_o, 32'd5);
        perf_clr_i = 1;
        idle(1'b1);
        chk("perf_cleared", perf_stall_cnt_o, 32'd0);
        perf_clr_i = 0;
        idle(1'b1);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            step(1'($urandom_range(0, 99) < 65), $urandom, 1'($urandom_range(0, 1)), a,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
